keypad_calc_core: RTL and testbench
===================================

Name: keypad_calc_core

Overview:
Parametrised successor to the 4x8 keypad calculator datapath. It combines a debounced 4x4 matrix-keypad scanner, a DATA_W x NUM_REGS register file and a flag-producing ALU. A sequencing FSM runs one command at a time over a valid/ready handshake. Sits between the pad/switch inputs and the display/status outputs of the top-level wrapper.

Parameters:
DATA_W, 8, datapath and register width (>=4)
ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W
SCAN_DIV, 4, clock cycles each keypad column is driven while scanning (>=1)
DEBOUNCE, 4, consecutive stable cycles required for key press and for key release (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
row_in  in  4  keypad rows, active-high
col_out  out  4  one-hot keypad column drive
key_valid  out  1  one-cycle pulse per debounced key press
key_code  out  4  last debounced key, {col[1:0], row[1:0]}
cmd_valid  in  1  command request
cmd_ready  out  1  core idle, command accepted when cmd_valid & cmd_ready
cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 WRITE_KEY
cmd_a  in  ADDR_W  source A register
cmd_b  in  ADDR_W  source B register
cmd_d  in  ADDR_W  destination register
res_valid  out  1  one-cycle pulse, result and flags valid
result  out  DATA_W  last result (held until next res_valid)
zero_flag  out  1  result == 0
carry_flag  out  1  carry/borrow/shifted-out bit

Behaviour:
- Reset (applies the same mid-operation): col_out=4'b0001, key_valid=0, key_code=0, key_pending=0, cmd_ready=1, res_valid=0, result=0, flags=0, all registers 0. Scanner goes to SCAN, sequencer goes to IDLE, any in-flight write is dropped.
- Scanner FSM SCAN -> PRESS_DB -> HELD -> RELEASE_DB -> SCAN.
- SCAN: column index increments every SCAN_DIV cycles (3 wraps to 0). col_out = 1<<col. Any row_in bit set -> PRESS_DB. Column freezes, candidate row = lowest set bit.
- PRESS_DB: needs DEBOUNCE consecutive cycles with row_in equal to the value sampled on entry. Any change -> back to SCAN, no pulse. On success: key_code <= {col, row}, key_valid pulses 1 cycle, key_pending <= 1, state HELD.
- HELD: stays while row_in != 0. row_in == 0 -> RELEASE_DB.
- RELEASE_DB: DEBOUNCE consecutive zero cycles -> SCAN, resuming from the frozen column. Any nonzero -> HELD.
- Exactly one key_valid per physical press, regardless of hold time.
- Sequencer FSM IDLE -> READ -> EXEC -> RESP -> IDLE.
- cmd_ready=1 only in IDLE. The accept edge captures op and addresses.
- READ latches rf[a] and rf[b].
- EXEC computes the result. On the same edge it writes rf[d] and updates result and flags.
- RESP drives res_valid=1 for one cycle.
- Latency: res_valid is high in the 3rd cycle after the accept edge. The next command can be accepted in the cycle after RESP, i.e. at most one command per 4 cycles.
- A, B and D may alias. Operands are read in READ, so the old values are used.
- ADD: A+B mod 2^DATA_W; carry = carry-out.
- SUB: A-B mod 2^DATA_W; carry = borrow (A<B unsigned).
- AND/OR/XOR: carry=0.
- SHL1: A<<1, zero fill; carry = A[DATA_W-1].
- SHR1: A>>1, logical; carry = A[0]. B is ignored.
- WRITE_KEY with key_pending=1: rf[d] <= zero-extended key_code, result = that value, carry=0, key_pending <= 0.
- WRITE_KEY with key_pending=0: no register write, result=0, zero=1, carry=0.
- A key_valid on the same edge as the WRITE_KEY consume: the old key_code is written and key_pending stays 1 (set wins).
- zero_flag = (result==0) for every op.
- cmd_valid held high through busy cycles is ignored until IDLE; no command is queued.

Test Plan:
1. Assert reset 2 cycles, including one cycle mid-EXEC of an ADD -> col_out=0001, cmd_ready=1, result=0, flags 0, destination register unchanged (0).
2. Drive row_in=0010 while col_out=0100, held 40 cycles -> exactly one key_valid, key_code=4'b1001. Then a 2-cycle glitch shorter than DEBOUNCE -> no key_valid.
3. Key 9 pending; WRITE_KEY d=1 -> rf[1]=9, result=9, res_valid 3 cycles after accept. Repeat WRITE_KEY with no new key -> result=0, zero=1, rf[1] stays 9.
4. ADD a=1,b=1,d=2 -> result=18, carry=0. SUB a=0,b=1,d=3 -> result=0xF7, carry=1. XOR a=1,b=1 -> result=0, zero=1.
5. rf[1]=9; SHL1 a=1,d=1 five times -> results 18, 36, 72, 144, then 32 with carry=1. SHR1 of 9 -> 4, carry=1.
6. cmd_valid held high 10 cycles -> exactly 3 accepts at 4-cycle spacing; cmd_ready=0 during READ/EXEC/RESP.

Source files
------------

// File: rtl/keypad_calc_core.sv
// Keypad calculator core: debounced 4x4 keypad scanner, small register file and a
// flag-producing ALU, sequenced one command at a time over a valid/ready handshake.
module keypad_calc_core #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  output logic              key_valid,
  output logic [3:0]        key_code,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_d,
  output logic              res_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DbW     = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StScan, StPressDb, StHeld, StRelDb} scan_e;
  typedef enum logic [1:0] {StIdle, StRead, StExec, StResp} seq_e;
  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr, OpWrKey
  } op_e;

  // Scanner state
  scan_e           scan_q, scan_d;
  logic [1:0]      col_q, col_d;
  logic [DivW-1:0] div_q, div_d;
  logic [DbW-1:0]  db_q, db_d;
  logic [3:0]      snap_q, snap_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      low_row;
  logic            key_set;
  logic            key_valid_q;
  logic [3:0]      key_code_q;
  logic            key_pending_q;

  // Sequencer / datapath state
  seq_e              seq_q, seq_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0] rf_q [NumRegs];
  logic [DATA_W-1:0] result_q;
  logic              zero_q, carry_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_we;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic              consume;

  // Lowest set row wins when several keys in the frozen column are down.
  always_comb begin
    low_row = 2'd0;
    if (row_in[0])      low_row = 2'd0;
    else if (row_in[1]) low_row = 2'd1;
    else if (row_in[2]) low_row = 2'd2;
    else if (row_in[3]) low_row = 2'd3;
  end

  // Scanner next-state: column stepping, press/release debounce.
  always_comb begin
    scan_d  = scan_q;
    col_d   = col_q;
    div_d   = div_q;
    db_d    = db_q;
    snap_d  = snap_q;
    row_d   = row_q;
    key_set = 1'b0;
    unique case (scan_q)
      StScan: begin
        if (row_in != 4'd0) begin
          scan_d = StPressDb;
          snap_d = row_in;
          row_d  = low_row;
          db_d   = '0;
          div_d  = '0;
        end else if (div_q == DivW'(SCAN_DIV - 1)) begin
          div_d = '0;
          col_d = col_q + 2'd1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StPressDb: begin
        if (row_in != snap_q) begin
          scan_d = StScan;
        end else if (db_q == DbW'(DEBOUNCE - 1)) begin
          scan_d  = StHeld;
          key_set = 1'b1;
        end else begin
          db_d = db_q + DbW'(1);
        end
      end
      StHeld: begin
        if (row_in == 4'd0) begin
          scan_d = StRelDb;
          db_d   = '0;
        end
      end
      StRelDb: begin
        if (row_in != 4'd0) begin
          scan_d = StHeld;
        end else if (db_q == DbW'(DEBOUNCE - 1)) begin
          scan_d = StScan;
        end else begin
          db_d = db_q + DbW'(1);
        end
      end
      default: scan_d = StScan;
    endcase
  end

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= StScan;
      col_q  <= 2'd0;
      div_q  <= '0;
      db_q   <= '0;
      snap_q <= 4'd0;
      row_q  <= 2'd0;
    end else begin
      scan_q <= scan_d;
      col_q  <= col_d;
      div_q  <= div_d;
      db_q   <= db_d;
      snap_q <= snap_d;
      row_q  <= row_d;
    end
  end

  // A consume here uses the old key_code; a new press on the same edge keeps pending set.
  assign consume = (seq_q == StExec) && (op_q == OpWrKey) && key_pending_q;

  // Key event registers: code, one-cycle pulse and pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pending_q <= 1'b0;
    end else begin
      key_valid_q <= key_set;
      if (key_set) begin
        key_code_q    <= {col_q, row_q};
        key_pending_q <= 1'b1;
      end else if (consume) begin
        key_pending_q <= 1'b0;
      end
    end
  end

  // Sequencer next-state: capture on accept, read operands, execute, respond.
  always_comb begin
    seq_d = seq_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    d_d   = d_q;
    opa_d = opa_q;
    opb_d = opb_q;
    unique case (seq_q)
      StIdle: begin
        if (cmd_valid) begin
          seq_d = StRead;
          op_d  = op_e'(cmd_op);
          a_d   = cmd_a;
          b_d   = cmd_b;
          d_d   = cmd_d;
        end
      end
      StRead: begin
        opa_d = rf_q[a_q];
        opb_d = rf_q[b_q];
        seq_d = StExec;
      end
      StExec:  seq_d = StResp;
      StResp:  seq_d = StIdle;
      default: seq_d = StIdle;
    endcase
  end

  // ALU on the latched operands; alu_we gates the register-file write.
  always_comb begin
    sum_ext   = {1'b0, opa_q} + {1'b0, opb_q};
    diff_ext  = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_we    = 1'b1;
    unique case (op_q)
      OpAdd: {alu_carry, alu_res} = sum_ext;
      OpSub: {alu_carry, alu_res} = diff_ext;
      OpAnd: alu_res = opa_q & opb_q;
      OpOr:  alu_res = opa_q | opb_q;
      OpXor: alu_res = opa_q ^ opb_q;
      OpShl: begin
        alu_res   = {opa_q[DATA_W-2:0], 1'b0};
        alu_carry = opa_q[DATA_W-1];
      end
      OpShr: begin
        alu_res   = {1'b0, opa_q[DATA_W-1:1]};
        alu_carry = opa_q[0];
      end
      OpWrKey: begin
        if (key_pending_q) alu_res = DATA_W'(key_code_q);
        else               alu_we  = 1'b0;
      end
      default: alu_we = 1'b0;
    endcase
  end

  // Sequencer state and captured command.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= StIdle;
      op_q  <= OpAdd;
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      seq_q <= seq_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      d_q   <= d_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  // Register file, result and flags update on the edge that ends EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else if (seq_q == StExec) begin
      if (alu_we) rf_q[d_q] <= alu_res;
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
      carry_q  <= alu_carry;
    end
  end

  // Output drive.
  always_comb begin
    col_out    = 4'b0001 << col_q;
    key_valid  = key_valid_q;
    key_code   = key_code_q;
    cmd_ready  = (seq_q == StIdle);
    res_valid  = (seq_q == StResp);
    result     = result_q;
    zero_flag  = zero_q;
    carry_flag = carry_q;
  end

endmodule

// File: tb/tb_keypad_calc_core.sv
// Bench for keypad_calc_core: directed keypad/command vectors, a timestamp-based
// transaction model checked every cycle, and literal expectations per command.
module tb_keypad_calc_core;

  localparam int MOD = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_a, cmd_b, cmd_d;
  logic       res_valid;
  logic [7:0] result;
  logic       zero_flag, carry_flag;

  always #5 clk = ~clk;

  keypad_calc_core #(
    .DATA_W  (8),
    .ADDR_W  (2),
    .SCAN_DIV(4),
    .DEBOUNCE(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_d     (cmd_d),
    .res_valid (res_valid),
    .result    (result),
    .zero_flag (zero_flag),
    .carry_flag(carry_flag)
  );

  int checks   = 0;
  int failures = 0;

  // Model: expected outputs for the cycle after each rising edge.
  logic       exp_ready, exp_rv, exp_zero, exp_carry;
  logic [7:0] exp_result;
  int         cyc = 0;
  int         acc_edge = -100;
  int         m_op, m_a, m_b, m_d;
  int         rf_m [4];
  int         noted = 0;
  int         used = 0;
  int         key_val = 0;
  bit         live = 1'b0;

  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int r, output bit c);
    c = 1'b0;
    r = 0;
    case (op)
      0: begin r = a + b; c = (r >= MOD); r = r % MOD; end
      1: begin c = (a < b); r = (a - b + MOD) % MOD; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin c = (a >= MOD / 2); r = (a * 2) % MOD; end
      6: begin c = (a % 2 == 1); r = a / 2; end
      default: r = 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept at edge t -> result/regs updated at edge t+2 -> ready again after edge t+3.
  task automatic model_loop();
    int r;
    bit c;
    forever begin
      @(posedge clk);
      if (reset) begin
        foreach (rf_m[i]) rf_m[i] = 0;
        exp_ready  = 1'b1;
        exp_rv     = 1'b0;
        exp_result = 8'd0;
        exp_zero   = 1'b0;
        exp_carry  = 1'b0;
        acc_edge   = -100;
        used       = noted;
        live       = 1'b1;
      end else begin
        exp_rv = 1'b0;
        if (cyc == acc_edge + 2) begin
          if (m_op == 7) begin
            c = 1'b0;
            if (noted > used) begin
              r = key_val;
              used = noted;
              rf_m[m_d] = r;
            end else begin
              r = 0;
            end
          end else begin
            alu_ref(m_op, rf_m[m_a], rf_m[m_b], r, c);
            rf_m[m_d] = r;
          end
          exp_result = 8'(r);
          exp_zero   = (r == 0);
          exp_carry  = c;
          exp_rv     = 1'b1;
        end
        if (exp_ready && cmd_valid) begin
          acc_edge = cyc;
          m_op = int'(cmd_op);
          m_a  = int'(cmd_a);
          m_b  = int'(cmd_b);
          m_d  = int'(cmd_d);
        end
        exp_ready = (cyc >= acc_edge + 3);
      end
      cyc++;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (live) begin
        checks++;
        if ({cmd_ready, res_valid, result, zero_flag, carry_flag} !==
            {exp_ready, exp_rv, exp_result, exp_zero, exp_carry}) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t: got rdy=%0b rv=%0b res=%0d z=%0b c=%0b expected rdy=%0b rv=%0b res=%0d z=%0b c=%0b",
                   $time, cmd_ready, res_valid, result, zero_flag, carry_flag,
                   exp_ready, exp_rv, exp_result, exp_zero, exp_carry);
        end
      end
    end
  endtask

  task automatic do_cmd(input int op, input int a, input int b, input int d,
                        input int exp_r, input int exp_z, input int exp_c, input string name);
    int w;
    int lat;
    @(negedge clk);
    cmd_op = 3'(op);
    cmd_a  = 2'(a);
    cmd_b  = 2'(b);
    cmd_d  = 2'(d);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_accept"}, int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_result"}, int'(result), exp_r);
    check({name, "_zero"}, int'(zero_flag), exp_z);
    check({name, "_carry"}, int'(carry_flag), exp_c);
  endtask

  initial begin
    int w;
    int pulses;
    int code;
    int acc;
    int idx [3];

    reset = 1'b1;
    row_in = 4'd0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_a = 2'd0;
    cmd_b = 2'd0;
    cmd_d = 2'd0;
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (2) @(negedge clk);
    check("rst_col", int'(col_out), 1);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    reset = 1'b0;

    // Key in column 2, row 1, held long.
    w = 0;
    while (col_out != 4'b0100 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("scan_reach_col2", int'(col_out), 4);
    row_in = 4'b0010;
    pulses = 0;
    code = 0;
    repeat (40) begin
      @(negedge clk);
      if (key_valid) begin
        pulses++;
        code = int'(key_code);
      end
    end
    check("held_col_frozen", int'(col_out), 4);
    row_in = 4'd0;
    repeat (12) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    check("press_pulses", pulses, 1);
    check("press_code", code, 9);
    key_val = 9;
    noted++;

    // Glitch shorter than the debounce window.
    row_in = 4'b0010;
    repeat (2) @(negedge clk);
    row_in = 4'd0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    check("glitch_pulses", pulses, 0);

    do_cmd(7, 0, 0, 1, 9, 0, 0, "wrkey_pending");
    do_cmd(7, 0, 0, 1, 0, 1, 0, "wrkey_empty");
    do_cmd(3, 1, 1, 1, 9, 0, 0, "or_read_r1");
    do_cmd(0, 1, 1, 2, 18, 0, 0, "add");
    do_cmd(1, 0, 1, 3, 247, 0, 1, "sub_borrow");
    do_cmd(4, 1, 1, 0, 0, 1, 0, "xor_self");
    do_cmd(6, 1, 0, 3, 4, 0, 1, "shr1");
    do_cmd(5, 1, 0, 1, 18, 0, 0, "shl1_a");
    do_cmd(5, 1, 0, 1, 36, 0, 0, "shl1_b");
    do_cmd(5, 1, 0, 1, 72, 0, 0, "shl1_c");
    do_cmd(5, 1, 0, 1, 144, 0, 0, "shl1_d");
    do_cmd(5, 1, 0, 1, 32, 0, 1, "shl1_e");

    // cmd_valid held for 10 cycles: ADD r1+r1 -> r1 with r1=32.
    @(negedge clk);
    cmd_op = 3'd0;
    cmd_a = 2'd1;
    cmd_b = 2'd1;
    cmd_d = 2'd1;
    cmd_valid = 1'b1;
    acc = 0;
    idx = '{0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin
        if (acc < 3) idx[acc] = i;
        acc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("hold_accepts", acc, 3);
    check("hold_spacing_1", idx[1] - idx[0], 4);
    check("hold_spacing_2", idx[2] - idx[1], 4);
    repeat (6) @(negedge clk);
    check("hold_final_result", int'(result), 0);
    check("hold_final_carry", int'(carry_flag), 1);

    // Reset while an ADD is in EXEC.
    @(negedge clk);
    cmd_op = 3'd0;
    cmd_a = 2'd1;
    cmd_b = 2'd1;
    cmd_d = 2'd2;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_col", int'(col_out), 1);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_res_valid", int'(res_valid), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_zero", int'(zero_flag), 0);
    check("midrst_carry", int'(carry_flag), 0);
    reset = 1'b0;
    do_cmd(3, 2, 2, 2, 0, 1, 0, "post_rst_r2");
    do_cmd(3, 3, 3, 3, 0, 1, 0, "post_rst_r3");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
